// File: rtl/fft_spectrum_pkg.sv
// Shared types and helpers for the FFT spectrum power/peak path.
// Holds the peak FSM states, the default power width and the tdata lane layout.
package fft_spectrum_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } peak_state_e;

  // Lane order inside tdata: re occupies lane 0, im occupies lane 1.
  localparam int RE_LANE_IDX = 0;
  localparam int IM_LANE_IDX = 1;

  function automatic int lane_lsb(input int lane_idx, input int lane_width);
    return lane_idx * lane_width;
  endfunction

  // Sum of two full-precision squares of a signed DATA_WIDTH value.
  function automatic int mag_width_default(input int data_width);
    return 2 * data_width;
  endfunction

endpackage

// File: rtl/fft_power_calc.sv
// Three-stage |X|^2 pipeline: register inputs, square each component, add.
// Valid, bin index and last travel alongside the data with identical latency.
module fft_power_calc
  import fft_spectrum_pkg::*;
#(
  parameter int DATA_WIDTH = 25,
  parameter int IDX_WIDTH  = 8,
  parameter int MAG_WIDTH  = mag_width_default(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] re_i,
  input  logic [DATA_WIDTH-1:0] im_i,
  input  logic [IDX_WIDTH-1:0]  idx_i,
  input  logic                  last_i,
  output logic                  valid_o,
  output logic [MAG_WIDTH-1:0]  mag_o,
  output logic [IDX_WIDTH-1:0]  idx_o,
  output logic                  last_o
);

  localparam int SQ_WIDTH = 2 * DATA_WIDTH;
  localparam int STAGES   = 3;

  logic signed [DATA_WIDTH-1:0] re_q, im_q;
  logic        [SQ_WIDTH-1:0]   sq_re_q, sq_im_q;
  logic        [MAG_WIDTH-1:0]  mag_q;

  logic                 valid_q [STAGES];
  logic [IDX_WIDTH-1:0] idx_q   [STAGES];
  logic                 last_q  [STAGES];

  // Squares are non-negative, so their SQ_WIDTH bit patterns are read as unsigned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      re_q    <= '0;
      im_q    <= '0;
      sq_re_q <= '0;
      sq_im_q <= '0;
      mag_q   <= '0;
    end else begin
      re_q    <= re_i;
      im_q    <= im_i;
      sq_re_q <= SQ_WIDTH'(re_q * re_q);
      sq_im_q <= SQ_WIDTH'(im_q * im_q);
      mag_q   <= MAG_WIDTH'(sq_re_q) + MAG_WIDTH'(sq_im_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_q[s] <= 1'b0;
        idx_q[s]   <= '0;
        last_q[s]  <= 1'b0;
      end
    end else begin
      valid_q[0] <= valid_i;
      idx_q[0]   <= idx_i;
      last_q[0]  <= last_i;
      for (int s = 1; s < STAGES; s++) begin
        valid_q[s] <= valid_q[s-1];
        idx_q[s]   <= idx_q[s-1];
        last_q[s]  <= last_q[s-1];
      end
    end
  end

  assign valid_o = valid_q[STAGES-1];
  assign idx_o   = idx_q[STAGES-1];
  assign last_o  = last_q[STAGES-1];
  assign mag_o   = mag_q;

endmodule

// File: rtl/fft_spectrum_peak.sv
// FFT output consumer: per-bin power stream plus per-frame maximum-power bin.
// Define FFT_PEAK_SKIP_DC_EN to exclude bin 0 from the peak search.
module fft_spectrum_peak
  import fft_spectrum_pkg::*;
#(
  parameter int LOG2_FFT_LEN = 8,
  parameter int DATA_WIDTH   = 25,
  parameter int LANE_WIDTH   = 32,
  parameter int USER_WIDTH   = 16,
  parameter int SEARCH_HALF  = 1,
  parameter int MAG_WIDTH    = mag_width_default(DATA_WIDTH)
) (
  input  logic                    i_aclk,
  input  logic                    i_rstn,
  input  logic                    i_axi4s_data_tvalid,
  input  logic [2*LANE_WIDTH-1:0] i_axi4s_data_tdata,
  input  logic                    i_axi4s_data_tlast,
  input  logic [USER_WIDTH-1:0]   i_axi4s_data_tuser,
  output logic                    o_mag_tvalid,
  output logic [MAG_WIDTH-1:0]    o_mag_tdata,
  output logic [LOG2_FFT_LEN-1:0] o_mag_tindex,
  output logic                    o_mag_tlast,
  output logic                    o_peak_valid,
  output logic [LOG2_FFT_LEN-1:0] o_peak_index,
  output logic [MAG_WIDTH-1:0]    o_peak_mag,
  output logic                    o_frame_err
);

  localparam int IW = LOG2_FFT_LEN;
  localparam int CW = LOG2_FFT_LEN + 1;
  localparam int N  = 1 << LOG2_FFT_LEN;
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [CW-1:0] CNT_SAT  = CW'(N + 1);
  localparam int RE_LSB = lane_lsb(RE_LANE_IDX, LANE_WIDTH);
  localparam int IM_LSB = lane_lsb(IM_LANE_IDX, LANE_WIDTH);

  logic                 pw_valid;
  logic [MAG_WIDTH-1:0] pw_mag;
  logic [IW-1:0]        pw_idx;
  logic                 pw_last;
  logic                 unused_inputs;

  // Lane padding and the upper tuser bits carry nothing for this block.
  assign unused_inputs = ^{i_axi4s_data_tdata, i_axi4s_data_tuser};

  fft_power_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IW),
    .MAG_WIDTH  (MAG_WIDTH)
  ) u_power (
    .clk_i   (i_aclk),
    .rst_ni  (i_rstn),
    .valid_i (i_axi4s_data_tvalid),
    .re_i    (i_axi4s_data_tdata[RE_LSB +: DATA_WIDTH]),
    .im_i    (i_axi4s_data_tdata[IM_LSB +: DATA_WIDTH]),
    .idx_i   (i_axi4s_data_tuser[IW-1:0]),
    .last_i  (i_axi4s_data_tlast),
    .valid_o (pw_valid),
    .mag_o   (pw_mag),
    .idx_o   (pw_idx),
    .last_o  (pw_last)
  );

  assign o_mag_tvalid = pw_valid;
  assign o_mag_tdata  = pw_mag;
  assign o_mag_tindex = pw_idx;
  assign o_mag_tlast  = pw_last;

  peak_state_e          state_q, state_d;
  logic [MAG_WIDTH-1:0] cur_max_q, cur_max_d;
  logic [IW-1:0]        cur_idx_q, cur_idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [MAG_WIDTH-1:0] peak_mag_q, peak_mag_d;
  logic [IW-1:0]        peak_idx_q, peak_idx_d;
  logic                 frame_err_q, frame_err_d;
  logic                 eligible;
  logic                 frame_start;

  always_comb begin
    eligible = 1'b1;
    if (SEARCH_HALF != 0 && pw_idx[IW-1]) eligible = 1'b0;
`ifdef FFT_PEAK_SKIP_DC_EN
    if (pw_idx == '0) eligible = 1'b0;
`else
    eligible = eligible & 1'b1;
`endif
  end

  // A beat arriving outside ACCUM (including the REPORT cycle) opens a new frame.
  assign frame_start = pw_valid && (state_q != ACCUM);

  always_ff @(posedge i_aclk or negedge i_rstn) begin
    if (!i_rstn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, REPORT: begin
        if (pw_valid)               state_d = pw_last ? REPORT : ACCUM;
        else                        state_d = IDLE;
      end
      ACCUM: if (pw_valid && pw_last) state_d = REPORT;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    o_peak_valid = (state_q == REPORT);
    o_peak_index = peak_idx_q;
    o_peak_mag   = peak_mag_q;
    o_frame_err  = frame_err_q;
  end

  always_comb begin
    cur_max_d   = cur_max_q;
    cur_idx_d   = cur_idx_q;
    cnt_d       = cnt_q;
    peak_mag_d  = peak_mag_q;
    peak_idx_d  = peak_idx_q;
    frame_err_d = frame_err_q;
    if (frame_start) begin
      cnt_d     = CW'(1);
      cur_max_d = eligible ? pw_mag : '0;
      cur_idx_d = eligible ? pw_idx : '0;
    end else if (pw_valid) begin
      cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
      if (eligible && (pw_mag > cur_max_q)) begin
        cur_max_d = pw_mag;
        cur_idx_d = pw_idx;
      end
    end
    // Results are captured with the closing beat so they hold through later frames.
    if (pw_valid && pw_last) begin
      peak_mag_d  = cur_max_d;
      peak_idx_d  = cur_idx_d;
      frame_err_d = (cnt_d != CNT_FULL);
    end
  end

  always_ff @(posedge i_aclk or negedge i_rstn) begin
    if (!i_rstn) begin
      cur_max_q   <= '0;
      cur_idx_q   <= '0;
      cnt_q       <= '0;
      peak_mag_q  <= '0;
      peak_idx_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cur_max_q   <= cur_max_d;
      cur_idx_q   <= cur_idx_d;
      cnt_q       <= cnt_d;
      peak_mag_q  <= peak_mag_d;
      peak_idx_q  <= peak_idx_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_fft_spectrum_peak.sv
// Directed bench for fft_spectrum_peak: one half-search and one full-search instance share stimulus.
// Expected peak for the DC case follows FFT_PEAK_SKIP_DC_EN.
module tb_fft_spectrum_peak;

  localparam int LG = 8;
  localparam int DW = 25;
  localparam int LW = 32;
  localparam int UW = 16;
  localparam int MW = 50;
  localparam int N  = 256;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          tvalid = 1'b0;
  logic [2*LW-1:0] tdata = '0;
  logic          tlast = 1'b0;
  logic [UW-1:0] tuser = '0;

  logic          mv_h, ml_h, pv_h, fe_h, mv_f, ml_f, pv_f, fe_f;
  logic [MW-1:0] md_h, pm_h, md_f, pm_f;
  logic [LG-1:0] mi_h, pi_h, mi_f, pi_f;

  fft_spectrum_peak #(.SEARCH_HALF(1)) dut_h (
    .i_aclk(clk), .i_rstn(rstn), .i_axi4s_data_tvalid(tvalid), .i_axi4s_data_tdata(tdata),
    .i_axi4s_data_tlast(tlast), .i_axi4s_data_tuser(tuser),
    .o_mag_tvalid(mv_h), .o_mag_tdata(md_h), .o_mag_tindex(mi_h), .o_mag_tlast(ml_h),
    .o_peak_valid(pv_h), .o_peak_index(pi_h), .o_peak_mag(pm_h), .o_frame_err(fe_h)
  );

  fft_spectrum_peak #(.SEARCH_HALF(0)) dut_f (
    .i_aclk(clk), .i_rstn(rstn), .i_axi4s_data_tvalid(tvalid), .i_axi4s_data_tdata(tdata),
    .i_axi4s_data_tlast(tlast), .i_axi4s_data_tuser(tuser),
    .o_mag_tvalid(mv_f), .o_mag_tdata(md_f), .o_mag_tindex(mi_f), .o_mag_tlast(ml_f),
    .o_peak_valid(pv_f), .o_peak_index(pi_f), .o_peak_mag(pm_f), .o_frame_err(fe_f)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] fre [N];
  logic [DW-1:0] fim [N];
  int            in_cyc [N];

  longint mag_seen [N];
  int     out_cyc  [N];
  int     mag_beats = 0;

  int     pk_n_h = 0, pk_n_f = 0;
  int     pk_idx_h [64], pk_cyc_h [64], pk_idx_f [64], pk_cyc_f [64];
  longint pk_mag_h [64], pk_mag_f [64];
  bit     pk_err_h [64], pk_err_f [64];

  always @(negedge clk) begin
    if (mv_h) begin
      mag_seen[mi_h] <= longint'(md_h);
      out_cyc[mi_h]  <= cyc;
      mag_beats      <= mag_beats + 1;
    end
    if (pv_h && pk_n_h < 64) begin
      pk_idx_h[pk_n_h] <= int'(pi_h);
      pk_mag_h[pk_n_h] <= longint'(pm_h);
      pk_err_h[pk_n_h] <= fe_h;
      pk_cyc_h[pk_n_h] <= cyc;
      pk_n_h           <= pk_n_h + 1;
    end
    if (pv_f && pk_n_f < 64) begin
      pk_idx_f[pk_n_f] <= int'(pi_f);
      pk_mag_f[pk_n_f] <= longint'(pm_f);
      pk_err_f[pk_n_f] <= fe_f;
      pk_cyc_f[pk_n_f] <= cyc;
      pk_n_f           <= pk_n_f + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int re_v, input int im_v);
    for (int i = 0; i < N; i++) begin
      fre[i] = DW'(re_v);
      fim[i] = DW'(im_v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives beats at negedges; bin index = beat number mod N, tlast on the final beat.
  task automatic send(input int nbeats, input int gap_pct, input int reset_at);
    for (int b = 0; b < nbeats; b++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        tvalid = 1'b0;
        tlast  = 1'b0;
        @(negedge clk);
      end
      if (b == reset_at) begin
        tvalid = 1'b0;
        rstn = 1'b0;
        #1;
        check("rst_mid_zero_h", {mv_h, md_h, mi_h, ml_h, pv_h, pi_h, pm_h, fe_h}, '0);
        check("rst_mid_zero_f", {mv_f, md_f, mi_f, ml_f, pv_f, pi_f, pm_f, fe_f}, '0);
        #1;
        rstn = 1'b1;
      end
      tvalid = 1'b1;
      tdata  = {{(LW-DW){fim[b%N][DW-1]}}, fim[b%N], {(LW-DW){fre[b%N][DW-1]}}, fre[b%N]};
      tuser  = UW'(b % N);
      tlast  = (b == nbeats - 1);
      in_cyc[b%N] = cyc;
      @(negedge clk);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  int bh, bf, beats0, bad;

  initial begin
    idle(3);
    check("reset_out_h", {mv_h, md_h, mi_h, ml_h, pv_h, pi_h, pm_h, fe_h}, '0);
    check("reset_out_f", {mv_f, md_f, mi_f, ml_f, pv_f, pi_f, pm_f, fe_f}, '0);
    rstn = 1'b1;
    idle(2);

    // Single tone at bin 37 over a floor of (1,1).
    fill(1, 1);
    fre[37] = DW'(1000);
    fim[37] = DW'(-1000);
    bh = pk_n_h; bf = pk_n_f;
    send(N, 0, -1);
    idle(8);
    check("tone_mag37", mag_seen[37], 2000000);
    check("tone_mag36", mag_seen[36], 2);
    check("tone_latency", out_cyc[37] - in_cyc[37], 3);
    check("tone_npulse", pk_n_h - bh, 1);
    check("tone_idx", pk_idx_h[bh], 37);
    check("tone_pmag", pk_mag_h[bh], 2000000);
    check("tone_err", pk_err_h[bh], 0);
    check("tone_pulse_lat", pk_cyc_h[bh] - in_cyc[N-1], 4);
    check("tone_idx_f", pk_idx_f[bf], 37);
    check("hold_idx", pi_h, 37);
    check("hold_valid_low", pv_h, 0);

    // Tie at bins 10/20 and a larger bin above the half range.
    fill(0, 0);
    fre[10] = DW'(500); fre[20] = DW'(500); fre[200] = DW'(900);
    bh = pk_n_h; bf = pk_n_f;
    send(N, 0, -1);
    idle(8);
    check("tie_idx_h", pk_idx_h[bh], 10);
    check("tie_mag_h", pk_mag_h[bh], 250000);
    check("tie_err_h", pk_err_h[bh], 0);
    check("full_idx_f", pk_idx_f[bf], 200);
    check("full_mag_f", pk_mag_f[bf], 810000);

    // Back-to-back frames with no idle cycle between them.
    fill(1, 0);
    fre[5] = DW'(700);
    bh = pk_n_h; bf = pk_n_f; beats0 = mag_beats;
    send(N, 0, -1);
    fill(1, 0);
    fre[250] = DW'(800);
    send(N, 0, -1);
    idle(8);
    check("b2b_npulse_f", pk_n_f - bf, 2);
    check("b2b_idx0_f", pk_idx_f[bf], 5);
    check("b2b_idx1_f", pk_idx_f[bf+1], 250);
    check("b2b_mag1_f", pk_mag_f[bf+1], 640000);
    check("b2b_spacing", pk_cyc_f[bf+1] - pk_cyc_f[bf], 256);
    check("b2b_err", {pk_err_f[bf], pk_err_f[bf+1]}, 0);
    check("b2b_beats", mag_beats - beats0, 512);
    check("b2b_idx0_h", pk_idx_h[bh], 5);
    check("b2b_idx1_h", pk_idx_h[bh+1], 0);
    check("b2b_mag1_h", pk_mag_h[bh+1], 1);

    // Random bubbles and the most negative input on both components.
    for (int i = 0; i < N; i++) begin
      fre[i] = DW'(i);
      fim[i] = DW'(-i);
    end
    fre[3] = 25'h1000000;
    fim[3] = 25'h1000000;
    bh = pk_n_h; bf = pk_n_f;
    send(N, 30, -1);
    idle(8);
    bad = 0;
    for (int i = 0; i < N; i++) if (out_cyc[i] - in_cyc[i] != 3) bad++;
    check("bub_latency_bad", bad, 0);
    check("bub_mag3", mag_seen[3], 64'd562949953421312);
    check("bub_mag255", mag_seen[255], 130050);
    check("bub_idx_h", pk_idx_h[bh], 3);
    check("bub_mag_h", pk_mag_h[bh], 64'd562949953421312);
    check("bub_idx_f", pk_idx_f[bf], 3);
    check("bub_err", pk_err_h[bh], 0);

    // Early tlast after 100 beats.
    fill(0, 0);
    fre[60] = DW'(300);
    bh = pk_n_h;
    send(100, 0, -1);
    idle(8);
    check("short_npulse", pk_n_h - bh, 1);
    check("short_idx", pk_idx_h[bh], 60);
    check("short_mag", pk_mag_h[bh], 90000);
    check("short_err", pk_err_h[bh], 1);

    // Reset at beat 50: earlier beats vanish, the remaining 206 form a short frame.
    fill(0, 0);
    fre[30] = DW'(2000);
    fre[120] = DW'(400);
    bh = pk_n_h; bf = pk_n_f;
    send(N, 0, 50);
    idle(8);
    check("rst_npulse", pk_n_h - bh, 1);
    check("rst_idx", pk_idx_h[bh], 120);
    check("rst_mag", pk_mag_h[bh], 160000);
    check("rst_err", pk_err_h[bh], 1);
    check("rst_err_f", pk_err_f[bf], 1);

    // DC bin dominance, resolved by the optional DC exclusion.
    fill(0, 0);
    fre[0] = DW'(30000);
    fre[7] = DW'(100);
    bh = pk_n_h;
    send(N, 0, -1);
    idle(8);
`ifdef FFT_PEAK_SKIP_DC_EN
    check("dc_idx", pk_idx_h[bh], 7);
    check("dc_mag", pk_mag_h[bh], 10000);
`else
    check("dc_idx", pk_idx_h[bh], 0);
    check("dc_mag", pk_mag_h[bh], 900000000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fft_spectrum_peak.md
Name: fft_spectrum_peak

Overview:
Downstream consumer of the 256-point FFT core's AXI4-Stream output.
- Per bin: computes power |X|^2 = re^2 + im^2 in a fixed-latency pipeline and forwards a power stream (for the HDMI spectrum display).
- Per frame: tracks the maximum-power bin and reports it once the frame closes.
- No backpressure: the FFT output has no tready, so every valid beat must be accepted.

Parameters:
- LOG2_FFT_LEN, 8, log2 of transform length; N = 2^LOG2_FFT_LEN.
- DATA_WIDTH, 25, significant signed width of re/im. Default = 16 input + 8 + 1 unscaled.
- LANE_WIDTH, 32, byte-padded lane width of each of re/im in tdata.
- USER_WIDTH, 16, tuser width.
- SEARCH_HALF, 1, 1 = peak search over bins 0..N/2-1 only; 0 = all N bins.
- MAG_WIDTH, 2*DATA_WIDTH, power output width; full precision, no truncation.

Ports:
- i_aclk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_axi4s_data_tvalid  in  1  FFT output beat valid
- i_axi4s_data_tdata  in  2*LANE_WIDTH  re = [DATA_WIDTH-1:0], im = [LANE_WIDTH+DATA_WIDTH-1:LANE_WIDTH], two's complement
- i_axi4s_data_tlast  in  1  last bin of frame
- i_axi4s_data_tuser  in  USER_WIDTH  [LOG2_FFT_LEN-1:0] = bin index, natural order
- o_mag_tvalid  out  1  power beat valid
- o_mag_tdata  out  MAG_WIDTH  re^2 + im^2, unsigned
- o_mag_tindex  out  LOG2_FFT_LEN  bin index of the power beat
- o_mag_tlast  out  1  last bin
- o_peak_valid  out  1  one-cycle pulse, peak result valid
- o_peak_index  out  LOG2_FFT_LEN  bin index of the maximum
- o_peak_mag  out  MAG_WIDTH  power at that bin
- o_frame_err  out  1  with o_peak_valid: beat count != N

Behaviour:
- Interface: one clock i_aclk; reset i_rstn is asynchronous, active-low.
- Reset: all outputs, pipeline valids, counters and peak registers are 0; FSM = IDLE.
- Power pipeline, 3 stages, fixed latency 3 cycles from input beat to o_mag_tvalid:
  - S1 registers re, im, index and last.
  - S2 squares each component: signed x signed, 2*DATA_WIDTH result.
  - S3 adds the squares, unsigned MAG_WIDTH. Max input (-2^24)^2*2 = 2^49 fits in 50 bits; no saturation.
  - Bubbles (tvalid low) propagate unchanged; valid/index/last travel with the data.
- Peak FSM runs on the S3 output:
  - IDLE: first valid beat loads cur_max = mag, cur_idx = index, cnt = 1. Go to ACCUM, or to REPORT if that beat has tlast.
  - ACCUM: each valid beat does cnt++. The beat is eligible if SEARCH_HALF = 0 or index < N/2. An eligible beat replaces the max only on strictly greater mag, so ties keep the lowest index. tlast goes to REPORT.
  - REPORT: a single cycle. o_peak_valid = 1; o_peak_index/o_peak_mag = final max, including the tlast beat's contribution; o_frame_err = (cnt != N). Then go to IDLE.
  - The next beat may arrive while in REPORT (back-to-back frames). It is treated as the first beat of a new frame in that same cycle (IDLE load) and the FSM goes to ACCUM. Zero dead cycles between frames.
- Boundaries:
  - A first beat that is ineligible (index >= N/2 with SEARCH_HALF = 1) loads cur_max = 0, cur_idx = 0.
  - cnt saturates at N+1, which is enough to flag overrun.
  - tlast early or late: the peak is still reported, with o_frame_err = 1.
  - Reset mid-frame: the partial frame is discarded. The trailing beats form a short frame, reported with o_frame_err = 1.
  - o_peak_* hold their value between pulses.

Optional Feature:
FFT_PEAK_SKIP_DC_EN
- Defined: bin 0 is never eligible. The first-beat rule then loads 0/0 if bin 0 arrives first. Suppresses the DC bias of unsigned ADC samples.
- Undefined: bin 0 is eligible like any other bin.

Decomposition:
- Package fft_spectrum_pkg holds:
  - the FSM state enum (IDLE, ACCUM, REPORT);
  - a function giving the default MAG_WIDTH from DATA_WIDTH;
  - the tdata lane-offset constants.
- One sub-module: fft_power_calc, the 3-stage squaring/add pipeline with its valid/index/last sideband. The peak FSM stays in the top.

Test Plan:
- Single tone: frame with bin 37 = (1000, -1000), all other bins = (1, 1), contiguous valids -> o_mag_tdata = 2000000 at index 37, 3 cycles after input; o_peak_valid pulse with index 37, mag 2000000, frame_err 0.
- Tie and half search: bins 10 and 20 both = (500, 0), bin 200 = (900, 0), SEARCH_HALF = 1 -> peak index 10, mag 250000. Bin 200 is ignored.
- Back-to-back frames: two 256-beat frames with no gap, peaks at 5 and 250 (SEARCH_HALF = 0) -> two pulses 256 cycles apart with indices 5 then 250; no beat lost.
- Bubbles and extremes: random tvalid gaps, bin 3 = (-2^24, -2^24) -> mag = 2^49 exact, peak index 3; the o_mag stream keeps the input gaps.
- Length error and reset: tlast at beat 100 -> peak with frame_err 1. Separately, assert i_rstn low at beat 50 -> all outputs 0 immediately; the remaining 206 beats report with frame_err 1.
- FFT_PEAK_SKIP_DC_EN: bin 0 = (30000, 0), bin 7 = (100, 0) -> defined: peak index 7; undefined: peak index 0.
